sample_strobe_sync: RTL and testbench

Single-clock sample capture block for the DDS datapath. It takes an unrelated slow-domain sample clock as a plain asynchronous input (`tick_async`) and synchronises it through a configurable flop chain. It edge-detects the result and captures a multi-channel data word into a holding register on each selected edge. The captured word is presented with a valid/ready handshake and overrun reporting, and feeds the downstream sample consumers (DAC/scope interface).

---
 rtl/sample_sync_pkg.sv | 22 ++
 rtl/sample_strobe_sync_if.sv | 42 ++++
 rtl/bit_sync_chain.sv | 22 ++
 rtl/sample_strobe_sync.sv | 116 +++++++++++
 tb/tb_sample_strobe_sync.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sample_sync_pkg.sv
// Shared constants and helpers for the sample strobe synchroniser.
package sample_sync_pkg;

    // Capture edge encoding for edge_sel.
    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    // Legal synchroniser depth range.
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Overrun counter width.
    localparam int unsigned OVR_CNT_W = 8;

    typedef logic [OVR_CNT_W-1:0] ovr_cnt_t;

    // Saturating increment for the overrun counter.
    function automatic ovr_cnt_t ovr_cnt_inc(input ovr_cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sample_strobe_sync_if.sv
// Capture-side bus of sample_strobe_sync: tick input, channel data and the
// valid/ready/overrun output handshake.
interface sample_strobe_sync_if #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned CHANNELS = 2
);
    logic                                tick_async;
    logic                                edge_sel;
    logic [CHANNELS-1:0]                 ch_en;
    logic [CHANNELS*WIDTH-1:0]           datain;
    logic [CHANNELS*WIDTH-1:0]           dataout;
    logic                                dout_valid;
    logic                                dout_ready;
    logic                                overrun;
    logic [sample_sync_pkg::OVR_CNT_W-1:0] overrun_cnt;

    // Capture block side: drives the held word and status.
    modport master (
        input  tick_async,
        input  edge_sel,
        input  ch_en,
        input  datain,
        input  dout_ready,
        output dataout,
        output dout_valid,
        output overrun,
        output overrun_cnt
    );

    // Producer/consumer side.
    modport slave (
        output tick_async,
        output edge_sel,
        output ch_en,
        output datain,
        output dout_ready,
        input  dataout,
        input  dout_valid,
        input  overrun,
        input  overrun_cnt
    );
endinterface

// File: rtl/bit_sync_chain.sv
// Single-bit asynchronous-input synchroniser: STAGES flops, async reset to 0.
module bit_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/sample_strobe_sync.sv
// Sample strobe synchroniser: syncs tick_async, edge-detects it and captures
// the enabled channels of datain into a held word with valid/ready and
// overrun reporting. Define SAMPLE_SYNC_OVERRUN_CNT_EN to build the
// saturating overrun counter; otherwise overrun_cnt is tied to 0.
module sample_strobe_sync
    import sample_sync_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               reset,
    sample_strobe_sync_if.master bus
);
    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sample_strobe_sync: SYNC_STAGES must be in 2..4");
    end

    logic                      tick_s;
    logic                      tick_p_q;
    logic [ARM_W-1:0]          arm_q;
    logic                      armed;
    logic                      sel_edge;
    logic                      cap;
    logic [CHANNELS*WIDTH-1:0] din_q;
    logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;

    bit_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.tick_async),
        .q     (tick_s)
    );

    // Arming keeps a tick that is already high at reset release from
    // looking like a fresh rising edge.
    assign armed = (arm_q == ARM_W'(ARM_MAX));

    // Select the capture edge and gate it with the arming state.
    always_comb begin
        sel_edge = 1'b0;
        unique case (bus.edge_sel)
            EDGE_RISE: sel_edge = tick_s & ~tick_p_q;
            EDGE_FALL: sel_edge = ~tick_s & tick_p_q;
        endcase
        cap = sel_edge & armed;
    end

    // Next-state for held word, valid and overrun; capture beats accept.
    always_comb begin
        dout_d = dout_q;
        if (cap) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (bus.ch_en[c]) begin
                    dout_d[c*WIDTH +: WIDTH] = din_q[c*WIDTH +: WIDTH];
                end
            end
        end
        if (cap) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        ovr_d = cap & valid_q & ~bus.dout_ready;
    end

    // Datapath and handshake state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_p_q <= 1'b0;
            arm_q    <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            tick_p_q <= tick_s;
            arm_q    <= armed ? arm_q : arm_q + 1'b1;
            din_q    <= bus.datain;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.dataout    = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = ovr_q;

`ifdef SAMPLE_SYNC_OVERRUN_CNT_EN
    ovr_cnt_t ovr_cnt_q;

    // Saturating count of overrun pulses, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_cnt_q <= '0;
        end else if (ovr_d) begin
            ovr_cnt_q <= ovr_cnt_inc(ovr_cnt_q);
        end
    end

    assign bus.overrun_cnt = ovr_cnt_q;
`else
    assign bus.overrun_cnt = '0;
`endif
endmodule

// File: tb/tb_sample_strobe_sync.sv
// Directed bench for sample_strobe_sync: table of tick/capture vectors plus
// hand-written latency, accept/capture collision, overrun, reset and stress
// sequences. A second instance with SYNC_STAGES=3 takes the random tick stress.
module tb_sample_strobe_sync;
    localparam int unsigned W  = 12;
    localparam int unsigned CH = 2;
`ifdef SAMPLE_SYNC_OVERRUN_CNT_EN
    localparam int unsigned CNT_EN = 1;
`else
    localparam int unsigned CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sample_strobe_sync_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
    sample_strobe_sync_if #(.WIDTH(W), .CHANNELS(CH)) bus3 ();

    sample_strobe_sync #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sample_strobe_sync #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    typedef struct {
        logic        tick;
        logic        sel;
        logic [1:0]  en;
        logic        rdy;
        logic [23:0] din;
        logic [23:0] exp_dout;
        logic        exp_v;
        logic        exp_o;
        logic        exp_va;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_ovr;
        int n_v;
        int rises;
        int caps;
        int ovrs3;
        logic lvl;

        //           tick  sel   en     rdy   din         exp_dout    v     o     va
        vecs[0] = '{1'b0, 1'b1, 2'b11, 1'b1, 24'h111222, 24'hABC123, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'b11, 1'b1, 24'h555444, 24'h555444, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 1'b1, 24'hFFF00F, 24'h55500F, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'b11, 1'b1, 24'h777888, 24'h55500F, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 2'b10, 1'b0, 24'hAAABBB, 24'hAAA00F, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 1'b0, 24'hCCCDDD, 24'hAAA00F, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 2'b11, 1'b0, 24'h123456, 24'h123456, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 2'b00, 1'b1, 24'h000000, 24'h123456, 1'b0, 1'b0, 1'b0};

        reset           = 1'b1;
        bus.tick_async  = 1'b0;
        bus.edge_sel    = 1'b1;
        bus.ch_en       = 2'b11;
        bus.datain      = '0;
        bus.dout_ready  = 1'b1;
        bus3.tick_async = 1'b0;
        bus3.edge_sel   = 1'b1;
        bus3.ch_en      = 2'b11;
        bus3.datain     = 24'h5A5A5A;
        bus3.dout_ready = 1'b1;
        step(3);
        check("rst_dataout", bus.dataout, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_ovr_cnt", bus.overrun_cnt, 0);
        reset = 1'b0;
        step(6);

        // Ready handshake and exact latency.
        bus.datain = 24'hABC123;
        step(2);
        bus.tick_async = 1'b1;
        step(1);
        check("hs_e0_valid", bus.dout_valid, 0);
        step(1);
        check("hs_e1_valid", bus.dout_valid, 0);
        step(1);
        check("hs_e2_valid", bus.dout_valid, 1);
        check("hs_e2_dataout", bus.dataout, 24'hABC123);
        check("hs_e2_overrun", bus.overrun, 0);
        step(1);
        check("hs_drop_valid", bus.dout_valid, 0);
        step(2);

        // Table-driven tick vectors.
        for (int i = 0; i < 8; i++) begin
            bus.edge_sel   = vecs[i].sel;
            bus.ch_en      = vecs[i].en;
            bus.dout_ready = vecs[i].rdy;
            bus.datain     = vecs[i].din;
            bus.tick_async = vecs[i].tick;
            step(3);
            check($sformatf("vec%0d_dataout", i), bus.dataout, vecs[i].exp_dout);
            check($sformatf("vec%0d_valid", i), bus.dout_valid, vecs[i].exp_v);
            check($sformatf("vec%0d_overrun", i), bus.overrun, vecs[i].exp_o);
            step(2);
            check($sformatf("vec%0d_valid_after", i), bus.dout_valid, vecs[i].exp_va);
        end
        check("ovr_cnt_one", bus.overrun_cnt, CNT_EN);

        // Capture on the same edge as an accept: valid stays, no overrun.
        bus.edge_sel   = 1'b1;
        bus.dout_ready = 1'b0;
        bus.ch_en      = 2'b11;
        bus.datain     = 24'h321654;
        bus.tick_async = 1'b0;
        step(5);
        bus.tick_async = 1'b1;
        step(5);
        check("coll_pre_valid", bus.dout_valid, 1);
        bus.datain     = 24'h9ABCDE;
        bus.tick_async = 1'b0;
        step(5);
        bus.tick_async = 1'b1;
        step(2);
        bus.dout_ready = 1'b1;
        step(1);
        check("coll_valid", bus.dout_valid, 1);
        check("coll_overrun", bus.overrun, 0);
        check("coll_dataout", bus.dataout, 24'h9ABCDE);
        step(1);
        check("coll_accept", bus.dout_valid, 0);
        check("coll_ovr_cnt", bus.overrun_cnt, CNT_EN);

        // 301 captures with no accept: the first fills, 300 overrun.
        bus.dout_ready = 1'b0;
        n_ovr = 0;
        for (int k = 0; k < 301; k++) begin
            bus.datain = 24'(k);
            bus.tick_async = 1'b0;
            for (int j = 0; j < 4; j++) begin
                step(1);
                if (bus.overrun) n_ovr++;
            end
            bus.tick_async = 1'b1;
            for (int j = 0; j < 4; j++) begin
                step(1);
                if (bus.overrun) n_ovr++;
            end
        end
        check("ovr_pulses", n_ovr, 300);
        check("ovr_last_data", bus.dataout, 24'd300);
        check("ovr_valid", bus.dout_valid, 1);
        check("ovr_cnt_sat", bus.overrun_cnt, CNT_EN * 255);

        // Reset with tick high and a word pending.
        reset = 1'b1;
        #1;
        check("mrst_dataout", bus.dataout, 0);
        check("mrst_valid", bus.dout_valid, 0);
        check("mrst_overrun", bus.overrun, 0);
        check("mrst_ovr_cnt", bus.overrun_cnt, 0);
        step(2);
        reset = 1'b0;
        n_v = 0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            if (bus.dout_valid || bus.overrun) n_v++;
        end
        check("mrst_no_capture", n_v, 0);
        check("mrst_dataout_held", bus.dataout, 0);
        bus.tick_async = 1'b0;
        step(5);
        bus.datain     = 24'hACEBDF;
        bus.tick_async = 1'b1;
        step(3);
        check("mrst_recap_valid", bus.dout_valid, 1);
        check("mrst_recap_data", bus.dataout, 24'hACEBDF);

        // Random tick stress on the 3-stage instance.
        step(10);
        lvl   = 1'b0;
        rises = 0;
        caps  = 0;
        ovrs3 = 0;
        for (int k = 0; k < 60; k++) begin
            int dur;
            lvl = ~lvl;
            if (lvl) rises++;
            bus3.tick_async = lvl;
            dur = int'($urandom_range(4, 9));
            for (int j = 0; j < dur; j++) begin
                step(1);
                if (bus3.dout_valid) caps++;
                if (bus3.overrun) ovrs3++;
            end
        end
        for (int j = 0; j < 10; j++) begin
            step(1);
            if (bus3.dout_valid) caps++;
            if (bus3.overrun) ovrs3++;
        end
        check("stress_captures", caps, rises);
        check("stress_overruns", ovrs3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
